// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes the board reset release, stretches it, then releases
// per-bank asynchronous clears one at a time, each gated by ACK or a per-bank timeout.
module rst_seq_ctrl #(
   parameter int unsigned NBANK       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned STRETCH     = 16,
   parameter int unsigned TMO         = 255,
   localparam int unsigned BW         = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic             CK,
   input  logic             RN,
   input  logic             SWRST,
   input  logic [NBANK-1:0] ACK,
   output logic [NBANK-1:0] CD,
   output logic             DONE,
   output logic             BUSY,
   output logic             ERR,
   output logic [BW-1:0]    ERRBANK
);

   localparam int unsigned CMAX = (STRETCH > TMO) ? STRETCH : TMO;
   localparam int unsigned CW   = $clog2(CMAX) + 1;

   localparam logic [1:0] ST_SYNC    = 2'd0;
   localparam logic [1:0] ST_STRETCH = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          idx_q, idx_d, idx_nxt;
   logic [NBANK-1:0]       cd_q, cd_d;
   logic                   err_q, err_d;
   logic [BW-1:0]          errbank_q, errbank_d;
   logic [SYNC_STAGES-2:0] sync_q;
   logic                   sync_out;
   logic                   ack_cur, tmo_hit;

   // The state register acts as the final synchronizer stage, so SYNC is left on edge
   // SYNC_STAGES and the stretch count starts from there.
   if (SYNC_STAGES > 2) begin : g_sync_chain
      always_ff @(posedge CK or negedge RN) begin
         if (!RN) sync_q <= '0;
         else     sync_q <= {sync_q[SYNC_STAGES-3:0], 1'b1};
      end
   end else begin : g_sync_single
      always_ff @(posedge CK or negedge RN) begin
         if (!RN) sync_q <= '0;
         else     sync_q <= 1'b1;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-2];
   assign idx_nxt  = idx_q + 1'b1;
   assign ack_cur  = ACK[idx_q];
   assign tmo_hit  = (cnt_q == CW'(TMO - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      cd_d      = cd_q;
      err_d     = err_q;
      errbank_d = errbank_q;
      case (state_q)
         ST_SYNC: begin
            if (sync_out) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         ST_STRETCH: begin
            cd_d = '1;
            if (cnt_q == CW'(STRETCH - 1)) begin
               cd_d[0] = 1'b0;
               state_d = ST_RELEASE;
               idx_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (ack_cur || tmo_hit) begin
               // An ACK arriving on the timeout edge wins; no error is flagged.
               if (!ack_cur) begin
                  err_d     = 1'b1;
                  errbank_d = idx_q;
               end
               cnt_d = '0;
               if (idx_q == BW'(NBANK - 1)) begin
                  state_d = ST_RUN;
               end else begin
                  idx_d         = idx_nxt;
                  cd_d[idx_nxt] = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            cd_d = '0;
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
      if (SWRST && (state_q != ST_SYNC)) begin
         cd_d    = '1;
         cnt_d   = '0;
         state_d = ST_STRETCH;
      end
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q   <= ST_SYNC;
         cnt_q     <= '0;
         idx_q     <= '0;
         cd_q      <= '1;
         err_q     <= 1'b0;
         errbank_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         cd_q      <= cd_d;
         err_q     <= err_d;
         errbank_q <= errbank_d;
      end
   end

   assign CD      = cd_q;
   assign DONE    = (state_q == ST_RUN);
   assign BUSY    = (state_q != ST_RUN);
   assign ERR     = err_q;
   assign ERRBANK = errbank_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed vector table and corner sequences, then random
// ACK/SWRST/RN stimulus checked every cycle against a timestamp-based reference model.
module tb_rst_seq_ctrl;

   localparam int NB = 4;
   localparam int SS = 2;
   localparam int ST = 16;
   localparam int TM = 255;

   logic          CK = 1'b0;
   logic          RN;
   logic          SWRST;
   logic [NB-1:0] ACK;
   logic [NB-1:0] CD;
   logic          DONE, BUSY, ERR;
   logic [1:0]    ERRBANK;

   logic       swrst1;
   logic [0:0] ack1;
   logic [0:0] cd1;
   logic       done1, busy1, err1;
   logic [0:0] errbank1;

   assign swrst1 = 1'b0;
   assign ack1   = 1'b1;

   always #5 CK = ~CK;

   rst_seq_ctrl #(.NBANK(NB), .SYNC_STAGES(SS), .STRETCH(ST), .TMO(TM)) dut (
      .CK(CK), .RN(RN), .SWRST(SWRST), .ACK(ACK), .CD(CD), .DONE(DONE), .BUSY(BUSY),
      .ERR(ERR), .ERRBANK(ERRBANK)
   );

   rst_seq_ctrl #(.NBANK(1), .SYNC_STAGES(SS), .STRETCH(ST), .TMO(TM)) dut1 (
      .CK(CK), .RN(RN), .SWRST(swrst1), .ACK(ack1), .CD(cd1), .DONE(done1), .BUSY(busy1),
      .ERR(err1), .ERRBANK(errbank1)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit auto_ack = 1'b1;
   logic [NB-1:0] stuck = '0;

   // Reference model: edge count since RN rose, edge deadlines, number of released banks.
   int m_e, m_stretch_end, m_nrel, m_last, m_errbank;
   bit m_started, m_done, m_err;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_e = 0; m_started = 0; m_stretch_end = 0; m_nrel = 0; m_last = 0;
      m_done = 0; m_err = 0; m_errbank = 0;
   endtask

   task automatic model_edge();
      int b;
      m_e++;
      if (!m_started) begin
         if (m_e == SS) begin
            m_started     = 1;
            m_stretch_end = m_e + ST;
         end
      end else if (SWRST) begin
         m_nrel        = 0;
         m_done        = 0;
         m_stretch_end = m_e + ST;
      end else if (m_nrel == 0) begin
         if (m_e == m_stretch_end) begin
            m_nrel = 1;
            m_last = m_e;
         end
      end else if (!m_done) begin
         b = m_nrel - 1;
         if (ACK[b] || (m_e == m_last + TM)) begin
            if (!ACK[b]) begin
               m_err     = 1;
               m_errbank = b;
            end
            if (m_nrel == NB) m_done = 1;
            else begin
               m_nrel++;
               m_last = m_e;
            end
         end
      end
   endtask

   task automatic check_model();
      logic [NB-1:0] exp_cd;
      exp_cd = m_done ? '0 : (4'b1111 << m_nrel);
      chk("model", {7'd0, CD, DONE, BUSY, ERR, ERRBANK},
          {7'd0, exp_cd, m_done, ~m_done, m_err, 2'(m_errbank)});
   endtask

   task automatic tick();
      @(posedge CK);
      cyc++;
      model_edge();
      #1;
      check_model();
      if (auto_ack) ACK = ~CD & ~stuck;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) tick();
   endtask

   // RN pulsed low for 3 ns between clock edges.
   task automatic rn_pulse();
      RN = 1'b0;
      #1;
      model_reset();
      check_model();
      #2;
      RN  = 1'b1;
      cyc = 0;
   endtask

   typedef struct {
      int         edge_no;
      logic [3:0] cd;
      logic       done;
      logic       busy;
      logic [4:0] one;   // {cd1, done1, busy1, err1, errbank1}
   } vec_t;

   vec_t tbl[7];
   int   e0, e1, e2, e3, f, mode, sb, rate;

   initial begin
      tbl[0] = '{0,  4'b1111, 1'b0, 1'b1, 5'b10100};
      tbl[1] = '{17, 4'b1111, 1'b0, 1'b1, 5'b10100};
      tbl[2] = '{18, 4'b1110, 1'b0, 1'b1, 5'b00100};
      tbl[3] = '{19, 4'b1100, 1'b0, 1'b1, 5'b01000};
      tbl[4] = '{20, 4'b1000, 1'b0, 1'b1, 5'b01000};
      tbl[5] = '{21, 4'b0000, 1'b0, 1'b1, 5'b01000};
      tbl[6] = '{22, 4'b0000, 1'b1, 1'b0, 5'b01000};

      RN = 1'b0; SWRST = 1'b0; ACK = '0;
      model_reset();
      repeat (2) @(posedge CK);
      #1;
      chk("reset_state", {7'd0, CD, DONE, BUSY, ERR, ERRBANK}, {7'd0, 4'b1111, 1'b1 == 1'b0,
          1'b1, 1'b0, 2'd0});
      #2;
      RN  = 1'b1;
      cyc = 0;

      // Nominal sequence, ACK one cycle after each release; NBANK=1 instance alongside.
      for (int k = 0; k < 7; k++) begin
         wait_to(tbl[k].edge_no);
         chk("seq_main", {10'd0, CD, DONE, BUSY},
             {10'd0, tbl[k].cd, tbl[k].done, tbl[k].busy});
         chk("seq_err", {15'd0, ERR}, 16'd0);
         chk("seq_nbank1", {11'd0, cd1, done1, busy1, err1, errbank1}, {11'd0, tbl[k].one});
      end

      // SWRST in RUN, then bank 2 never acknowledges.
      SWRST = 1'b1;
      tick();
      SWRST = 1'b0;
      chk("swrst_run", {11'd0, CD, DONE}, {11'd0, 4'b1111, 1'b0});
      e0 = cyc;
      stuck = 4'b0100;
      wait_to(e0 + 15);
      chk("swrst_hold", {12'd0, CD}, {12'd0, 4'b1111});
      wait_to(e0 + 16);
      chk("swrst_rel0", {12'd0, CD}, {12'd0, 4'b1110});
      f = e0 + 18;
      wait_to(f + 254);
      chk("tmo_before", {11'd0, CD, ERR}, {11'd0, 4'b1000, 1'b0});
      wait_to(f + 255);
      chk("tmo_hit", {9'd0, CD, ERR, ERRBANK}, {9'd0, 4'b0000, 1'b1, 2'd2});
      wait_to(f + 256);
      chk("tmo_done", {13'd0, DONE, ERR, BUSY}, {13'd0, 1'b1, 1'b1, 1'b0});

      // SWRST while bank 1 released and bank 2 waiting; ERR must survive.
      stuck = 4'b0010;
      SWRST = 1'b1;
      tick();
      SWRST = 1'b0;
      e1 = cyc;
      wait_to(e1 + 19);
      chk("mid_release", {12'd0, CD}, {12'd0, 4'b1100});
      SWRST = 1'b1;
      tick();
      SWRST = 1'b0;
      stuck = '0;
      chk("swrst_mid", {7'd0, CD, DONE, BUSY, ERR, ERRBANK},
          {7'd0, 4'b1111, 1'b0, 1'b1, 1'b1, 2'd2});
      e2 = cyc;
      wait_to(e2 + 15);
      chk("swrst_mid_hold", {12'd0, CD}, {12'd0, 4'b1111});
      wait_to(e2 + 16);
      chk("swrst_mid_rel0", {12'd0, CD}, {12'd0, 4'b1110});

      // ACK[0] and SWRST on the same edge: SWRST wins, CD[1] stays set.
      SWRST = 1'b1;
      tick();
      SWRST = 1'b0;
      chk("swrst_vs_ack", {11'd0, CD, BUSY}, {11'd0, 4'b1111, 1'b1});
      e3 = cyc;
      wait_to(e3 + 16);
      chk("swrst_vs_ack_rel", {12'd0, CD}, {12'd0, 4'b1110});
      wait_to(e3 + 20);
      chk("rerun_done", {9'd0, CD, DONE, ERR, ERRBANK}, {9'd0, 4'b0000, 1'b1, 1'b1, 2'd2});

      // RN pulse in RUN clears everything immediately, then the full sequence repeats.
      RN = 1'b0;
      #1;
      chk("rn_pulse", {7'd0, CD, DONE, BUSY, ERR, ERRBANK},
          {7'd0, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0});
      model_reset();
      #2;
      RN  = 1'b1;
      cyc = 0;
      ACK = '0;
      wait_to(17);
      chk("rn_hold", {12'd0, CD}, {12'd0, 4'b1111});
      wait_to(18);
      chk("rn_rel0", {12'd0, CD}, {12'd0, 4'b1110});
      wait_to(22);
      chk("rn_done", {13'd0, DONE, ERR, BUSY}, {13'd0, 1'b1, 1'b0, 1'b0});

      // Random episodes checked by the model on every edge.
      auto_ack = 1'b0;
      for (int ep = 0; ep < 12; ep++) begin
         mode = $urandom_range(0, 2);
         sb   = $urandom_range(0, NB - 1);
         rate = (mode == 2 || ep % 3 == 0) ? 0 : 40;
         for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NB; b++) begin
               case (mode)
                  0:       ACK[b] = ($urandom_range(0, 1) == 0);
                  1:       ACK[b] = ($urandom_range(0, 15) == 0);
                  default: ACK[b] = (b != sb) && ($urandom_range(0, 1) == 0);
               endcase
            end
            SWRST = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
            if ($urandom_range(0, 299) == 0) rn_pulse();
            tick();
         end
      end
      SWRST = 1'b0;
      ACK   = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
